// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game blocks (bullet control, explosion FSM).
package tank_game_pkg;

    typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
    typedef enum logic [1:0] {IDLE, FLYING, HIT, RELEASE} bullet_state_t;

    localparam int SCREEN_W_DFLT = 640;
    localparam int SCREEN_H_DFLT = 480;

    // Last frame index of the explosion animation; the bullet drops its flag after it.
    localparam logic [3:0] EXPLODE_LAST_FRAME = 4'd11;

endpackage

// File: rtl/aabb_overlap.sv
// Strict axis-aligned box overlap test between two squares; touching edges do not overlap.
module aabb_overlap #(
    parameter int A_SIZE = 4,
    parameter int B_SIZE = 32
) (
    input  logic [9:0] a_x,
    input  logic [9:0] a_y,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic       overlap
);

    localparam logic [10:0] AS = 11'(A_SIZE);
    localparam logic [10:0] BS = 11'(B_SIZE);

    // One extra bit so that coordinate + size never wraps.
    logic [10:0] ax, ay, bx, by;
    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    assign overlap = (ax + AS > bx) && (ax < bx + BS) &&
                     (ay + AS > by) && (ay < by + BS);

endmodule

// File: rtl/tank_bullet_ctrl.sv
// Single-bullet lifecycle: fire capture, motion, edge kill, hit detection, explosion handshake.
// Optional BULLET_WRAP_EN: wrap at screen edges and expire after MAX_FLIGHT_FRAMES instead.
module tank_bullet_ctrl
    import tank_game_pkg::*;
#(
    parameter int SCREEN_W          = SCREEN_W_DFLT,
    parameter int SCREEN_H          = SCREEN_H_DFLT,
    parameter int BULLET_SIZE       = 4,
    parameter int TANK_SIZE         = 32,
    parameter int BULLET_SPEED      = 4
`ifdef BULLET_WRAP_EN
   ,parameter int MAX_FLIGHT_FRAMES = 255
`endif
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       fire,
    input  logic [9:0] shooter_x,
    input  logic [9:0] shooter_y,
    input  logic [1:0] shooter_dir,
    input  logic [9:0] tank_x,
    input  logic [9:0] tank_y,
    input  logic [3:0] explode_frame,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic       bull_collide_flag,
    output logic [3:0] hit_count
);

    localparam logic [10:0] SPD   = 11'(BULLET_SPEED);
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - BULLET_SIZE);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - BULLET_SIZE);

    bullet_state_t state, state_next;
    dir_t          dir_q, dir_next;
    logic [9:0]    x_next, y_next;
    logic [3:0]    hit_next;
    logic          fire_q, fire_pulse, overlap;
    logic [10:0]   x11, y11;

    assign fire_pulse = fire & ~fire_q;
    assign x11 = {1'b0, bullet_x};
    assign y11 = {1'b0, bullet_y};

    aabb_overlap #(.A_SIZE(BULLET_SIZE), .B_SIZE(TANK_SIZE)) u_hit (
        .a_x(bullet_x), .a_y(bullet_y), .b_x(tank_x), .b_y(tank_y), .overlap(overlap)
    );

`ifdef BULLET_WRAP_EN
    localparam logic [10:0] SW = 11'(SCREEN_W);
    localparam logic [10:0] SH = 11'(SCREEN_H);
    logic [7:0] flight_cnt, flight_next;
`else
    logic edge_out;
    always_comb begin
        edge_out = 1'b0;
        case (dir_q)
            UP:    edge_out = y11 < SPD;
            LEFT:  edge_out = x11 < SPD;
            RIGHT: edge_out = x11 + SPD > X_MAX;
            DOWN:  edge_out = y11 + SPD > Y_MAX;
            default: edge_out = 1'b1;
        endcase
    end
`endif

    always_comb begin
        state_next        = state;
        dir_next          = dir_q;
        x_next            = bullet_x;
        y_next            = bullet_y;
        hit_next          = hit_count;
        bullet_active     = 1'b0;
        bull_collide_flag = 1'b0;
`ifdef BULLET_WRAP_EN
        flight_next       = flight_cnt;
`endif
        case (state)
            IDLE: begin
                if (fire_pulse) begin
                    x_next     = shooter_x;
                    y_next     = shooter_y;
                    dir_next   = dir_t'(shooter_dir);
                    state_next = FLYING;
`ifdef BULLET_WRAP_EN
                    flight_next = 8'd0;
`endif
                end
            end
            FLYING: begin
                bullet_active = 1'b1;
`ifdef BULLET_WRAP_EN
                flight_next = flight_cnt + 8'd1;
`endif
                if (overlap) begin
                    state_next = HIT;
                    if (hit_count != 4'd15) hit_next = hit_count + 4'd1;
                end
`ifdef BULLET_WRAP_EN
                else if (flight_next == 8'(MAX_FLIGHT_FRAMES)) begin
                    state_next = IDLE;
                end else begin
                    case (dir_q)
                        UP:    y_next = (y11 < SPD) ? 10'(y11 + SH - SPD) : 10'(y11 - SPD);
                        LEFT:  x_next = (x11 < SPD) ? 10'(x11 + SW - SPD) : 10'(x11 - SPD);
                        RIGHT: x_next = (x11 + SPD >= SW) ? 10'(x11 + SPD - SW) : 10'(x11 + SPD);
                        default: y_next = (y11 + SPD >= SH) ? 10'(y11 + SPD - SH) : 10'(y11 + SPD);
                    endcase
                end
`else
                else if (edge_out) begin
                    state_next = IDLE;
                end else begin
                    case (dir_q)
                        UP:    y_next = 10'(y11 - SPD);
                        LEFT:  x_next = 10'(x11 - SPD);
                        RIGHT: x_next = 10'(x11 + SPD);
                        default: y_next = 10'(y11 + SPD);
                    endcase
                end
`endif
            end
            HIT: begin
                bull_collide_flag = 1'b1;
                if (explode_frame == EXPLODE_LAST_FRAME) state_next = RELEASE;
            end
            // One flag-low cycle so the explosion FSM can leave its last frame.
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= IDLE;
            dir_q     <= UP;
            bullet_x  <= '0;
            bullet_y  <= '0;
            hit_count <= '0;
            fire_q    <= 1'b0;
`ifdef BULLET_WRAP_EN
            flight_cnt <= '0;
`endif
        end else begin
            state     <= state_next;
            dir_q     <= dir_next;
            bullet_x  <= x_next;
            bullet_y  <= y_next;
            hit_count <= hit_next;
            fire_q    <= fire;
`ifdef BULLET_WRAP_EN
            flight_cnt <= flight_next;
`endif
        end
    end

endmodule

// File: doc/tank_bullet_ctrl.md
Name: tank_bullet_ctrl

Overview:
Owns one bullet's lifecycle: fire capture, per-frame motion, edge kill and hit detection against the target tank's bounding box. Sits directly upstream of the explosion-frame FSM. Drives bull_collide_flag and holds it until the downstream explosion reports its last frame. Exports bullet position to the sprite renderer and a saturating hit counter to the score display.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BULLET_SIZE, 4, bullet square side in pixels
TANK_SIZE, 32, target tank square side in pixels
BULLET_SPEED, 4, pixels moved per frame_clk
MAX_FLIGHT_FRAMES, 255, flight lifetime; used only with BULLET_WRAP_EN

Ports:
frame_clk  in  1  frame-rate clock
Reset  in  1  synchronous, active-high
fire  in  1  level fire button; a rising edge requests a shot
shooter_x  in  10  shooter muzzle x, latched at fire
shooter_y  in  10  shooter muzzle y, latched at fire
shooter_dir  in  2  0=up, 1=right, 2=down, 3=left; latched at fire
tank_x  in  10  target tank top-left x
tank_y  in  10  target tank top-left y
explode_frame  in  4  current frame index from the explosion FSM
bullet_x  out  10  bullet top-left x
bullet_y  out  10  bullet top-left y
bullet_active  out  1  bullet is drawn
bull_collide_flag  out  1  hit indication to the explosion FSM
hit_count  out  4  total hits, saturating

Behaviour:
- Reset (sync, active-high, frame_clk): state=IDLE; all outputs 0; fire_q=0. Reset mid-flight or mid-HIT aborts immediately; flag is 0 the following cycle.
- Fire edge detect: fire_q is registered every cycle. fire_pulse = fire & ~fire_q. The pulse is honoured only in IDLE; in every other state it is dropped, not queued.
- IDLE: bullet_active=0, flag=0.
  - On fire_pulse: latch bullet_x/y=shooter_x/y and dir=shooter_dir, then go to FLYING.
- FLYING: bullet_active=1. Priority order per cycle:
  1. Overlap of the current registered position with the tank box: go to HIT; position frozen; hit_count+1, saturating at 15.
  2. Else if the next position is out of bounds: go to IDLE.
     - up: y < BULLET_SPEED
     - left: x < BULLET_SPEED
     - right: x + BULLET_SPEED > SCREEN_W - BULLET_SIZE
     - down: y + BULLET_SPEED > SCREEN_H - BULLET_SIZE
  3. Else move by BULLET_SPEED in dir.
  - Compute all bounds in 11-bit unsigned arithmetic to avoid wrap.
- Overlap rule (strict):
  - bullet_x + BULLET_SIZE > tank_x and bullet_x < tank_x + TANK_SIZE
  - same test for y
  - Touching edges do not count as overlap.
- HIT: bullet_active=0, flag=1. Stay while explode_frame != 11; on explode_frame == 11 go to RELEASE.
- RELEASE: flag=0 for exactly one cycle (lets the downstream FSM leave its last state), then IDLE. A fire_pulse in this cycle is dropped.
- Latency: flag rises the cycle after the overlapping position is registered.
- The tank may move during HIT; this has no effect.
- Illegal state encoding recovers to IDLE with outputs 0.

Optional Feature:
BULLET_WRAP_EN
- Defined: out-of-bounds moves wrap modulo SCREEN_W/SCREEN_H instead of killing the bullet.
  - An 8-bit flight counter clears at fire and increments each FLYING cycle.
  - Reaching MAX_FLIGHT_FRAMES goes to IDLE; collision still has priority.
- Undefined: edge kill as above; the counter is not instantiated.

Decomposition:
- Package tank_game_pkg:
  - dir_t enum (UP, RIGHT, DOWN, LEFT)
  - bullet_state_t enum (IDLE, FLYING, HIT, RELEASE)
  - SCREEN_W/SCREEN_H defaults
  - EXPLODE_LAST_FRAME = 4'd11, shared with the explosion FSM
- Sub-module aabb_overlap: combinational, parameterised box sizes, one instance for the bullet-vs-tank test.

Test Plan:
- Reset then idle: Reset high for 2 cycles, then fire held 0 -> all outputs 0, bullet_active stays 0.
- Clean hit:
  - Stimulus: shooter (100,200), dir=1, tank (200,192), fire rising edge.
  - Required: x steps 100, 104, …, 200; bull_collide_flag=1 on the 26th cycle after the state reaches FLYING; hit_count=1.
  - Then drive explode_frame=11: flag=0 on the next cycle for 1 cycle, then IDLE.
- Edge kill: shooter (630,10), dir=1 -> x=634 after one move, next cycle IDLE with bullet_active=0, hit_count unchanged.
- Fire ignored during HIT: while in HIT, pulse fire 3 times -> no new bullet; after RELEASE, one new rising edge launches from the current shooter_x/y.
- Saturation: 17 consecutive hits -> hit_count holds at 15.
- Reset mid-HIT: assert Reset while flag=1 -> next cycle flag=0, hit_count=0, state IDLE; with BULLET_WRAP_EN, a dir=3 shot from x=0 wraps to x=636.
